// File: rtl/fifo_axis_reader_if.sv
// Signal bundle between the FIFO read port, the drain engine and the AXI4-Stream sink.
`timescale 1ns/1ps
interface fifo_axis_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_enable;
    logic                  o_rd_en;
    logic [DATA_WIDTH-1:0] i_rd_data;
    logic                  i_rd_valid;
    logic                  i_empty;
    logic [DATA_WIDTH-1:0] o_m_axis_tdata;
    logic                  o_m_axis_tvalid;
    logic                  o_m_axis_tlast;
    logic                  i_m_axis_tready;
    logic                  o_pkt_done;
    logic                  o_overflow;

    modport master (
        input  i_enable,
        output o_rd_en,
        input  i_rd_data,
        input  i_rd_valid,
        input  i_empty,
        output o_m_axis_tdata,
        output o_m_axis_tvalid,
        output o_m_axis_tlast,
        input  i_m_axis_tready,
        output o_pkt_done,
        output o_overflow
    );

    modport slave (
        output i_enable,
        input  o_rd_en,
        output i_rd_data,
        output i_rd_valid,
        output i_empty,
        input  o_m_axis_tdata,
        input  o_m_axis_tvalid,
        input  o_m_axis_tlast,
        output i_m_axis_tready,
        input  o_pkt_done,
        input  o_overflow
    );
endinterface

// File: rtl/fifo_axis_reader.sv
// FIFO read-side drain engine: absorbs the registered FIFO read latency in a
// 2-entry skid buffer and emits an AXI4-Stream with tlast every PACKET_LEN beats.
`timescale 1ns/1ps
module fifo_axis_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int PACKET_LEN = 16
) (
    input  logic               i_clk,
    input  logic               i_s_rst,
    fifo_axis_reader_if.master bus
);
    localparam int BW = $clog2(PACKET_LEN + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(PACKET_LEN - 1);

    logic [1:0]            occ;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    logic [BW-1:0]         beat;
    logic                  pkt_done;
    logic                  overflow;

    logic       tvalid;
    logic       tlast;
    logic       pop;
    logic       push;
    logic       rd_en;
    logic [2:0] pending;

    always_comb begin
        tvalid  = (occ != 2'd0);
        tlast   = tvalid & (beat == LAST_BEAT);
        pop     = tvalid & bus.i_m_axis_tready;
        push    = bus.i_rd_valid & ~i_s_rst;
        // Words buffered plus the one in flight, minus the one leaving now.
        pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        rd_en   = ~i_s_rst & bus.i_enable & ~bus.i_empty & (pending < 3'd2);
    end

    always_ff @(posedge i_clk) begin
        if (i_s_rst) begin
            occ      <= '0;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            beat     <= '0;
            pkt_done <= 1'b0;
            overflow <= 1'b0;
        end else begin
            inflight <= rd_en;
            pkt_done <= pop & tlast;
            if (pop) begin
                beat <= tlast ? '0 : beat + BW'(1);
            end

            if (push && !pop) begin
                case (occ)
                    2'd0: begin
                        head <= bus.i_rd_data;
                        occ  <= 2'd1;
                    end
                    2'd1: begin
                        tail <= bus.i_rd_data;
                        occ  <= 2'd2;
                    end
                    default: overflow <= 1'b1;
                endcase
            end else if (!push && pop) begin
                head <= tail;
                occ  <= occ - 2'd1;
            end else if (push && pop) begin
                // Occupancy holds; the next-oldest word moves to the head.
                if (occ == 2'd2) begin
                    head <= tail;
                    tail <= bus.i_rd_data;
                end else begin
                    head <= bus.i_rd_data;
                end
            end
        end
    end

    assign bus.o_rd_en         = rd_en;
    assign bus.o_m_axis_tdata  = head;
    assign bus.o_m_axis_tvalid = tvalid;
    assign bus.o_m_axis_tlast  = tlast;
    assign bus.o_pkt_done      = pkt_done;
    assign bus.o_overflow      = overflow;
endmodule

// File: tb/tb_fifo_axis_reader.sv
// Directed bench for fifo_axis_reader against a behavioural registered-read FIFO.
`timescale 1ns/1ps
module tb_fifo_axis_reader;
    logic clk;
    logic rst;
    logic fifo_clr;
    int   tests;
    int   fails;
    int   cyc;
    int   done_cnt;

    logic [7:0]  fmem [0:255];
    int unsigned wptr;
    int unsigned rptr;

    logic [7:0] got_data [$];
    logic       got_last [$];
    int         got_cyc  [$];

    fifo_axis_reader_if #(.DATA_WIDTH(8)) bus ();

    fifo_axis_reader #(.DATA_WIDTH(8), .PACKET_LEN(16)) dut (
        .i_clk   (clk),
        .i_s_rst (rst),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: one-cycle registered read, never reset by the DUT reset.
    assign bus.i_empty = (rptr == wptr);
    always @(posedge clk) begin
        if (fifo_clr) begin
            rptr           <= 0;
            bus.i_rd_valid <= 1'b0;
        end else begin
            bus.i_rd_valid <= bus.o_rd_en;
            if (bus.o_rd_en) begin
                bus.i_rd_data <= fmem[rptr[7:0]];
                rptr          <= rptr + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus.o_m_axis_tvalid && bus.i_m_axis_tready) begin
            got_data.push_back(bus.o_m_axis_tdata);
            got_last.push_back(bus.o_m_axis_tlast);
            got_cyc.push_back(cyc);
        end
        if (!rst && bus.o_pkt_done) done_cnt = done_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        rst                 = 1'b1;
        bus.i_enable        = 1'b1;
        bus.i_m_axis_tready = 1'b1;
        fifo_clr            = 1'b1;
        tick();
        tick();
        fifo_clr = 1'b0;
        wptr     = 0;
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic load(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fmem[wptr[7:0]] = 8'(base + 8'(i));
            wptr            = wptr + 1;
        end
    endtask

    task automatic wait_beats(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (got_data.size() < n && k < budget) begin
            tick();
            k++;
        end
        tests++;
        if (got_data.size() < n) begin
            fails++;
            $display("FAIL %s timeout: beats got %0d need %0d", name, got_data.size(), n);
        end
    endtask

    task automatic test_reset();
        start();
        load(8'h40, 32);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if ({bus.o_rd_en, bus.o_m_axis_tvalid, bus.o_m_axis_tdata, bus.o_m_axis_tlast,
                 bus.o_pkt_done, bus.o_overflow} !== 13'd0) begin
                fails++;
                $display("FAIL reset_outputs cyc%0d: rd_en=%b tvalid=%b tdata=%h tlast=%b done=%b ovf=%b need all 0",
                         i, bus.o_rd_en, bus.o_m_axis_tvalid, bus.o_m_axis_tdata, bus.o_m_axis_tlast,
                         bus.o_pkt_done, bus.o_overflow);
            end
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({bus.o_rd_en, bus.o_m_axis_tvalid} !== 2'b10) begin
            fails++;
            $display("FAIL release_c0: rd_en=%b tvalid=%b need 1 0", bus.o_rd_en, bus.o_m_axis_tvalid);
        end
        tick();
        @(negedge clk);
        tests++;
        if (bus.o_m_axis_tvalid !== 1'b0) begin
            fails++;
            $display("FAIL release_c1: tvalid=%b need 0", bus.o_m_axis_tvalid);
        end
        tick();
        @(negedge clk);
        tests++;
        if (bus.o_m_axis_tvalid !== 1'b1 || bus.o_m_axis_tdata !== 8'h40) begin
            fails++;
            $display("FAIL release_c2: tvalid=%b tdata=%h need 1 40", bus.o_m_axis_tvalid, bus.o_m_axis_tdata);
        end
    endtask

    task automatic test_stream();
        int run;
        int total;
        int bad;
        start();
        load(8'h00, 32);
        rst   = 1'b0;
        run   = 0;
        total = 0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (bus.o_rd_en === 1'b1) begin
                total++;
                if (i == run) run++;
            end
            tick();
        end
        tests++;
        if (run != 32 || total != 32) begin
            fails++;
            $display("FAIL stream_rd_en: run=%0d total=%0d need 32 32", run, total);
        end
        wait_beats(32, 20, "stream");
        repeat (3) tick();
        bad = 0;
        for (int i = 0; i < got_data.size(); i++) begin
            if (got_data[i] !== 8'(i) || got_cyc[i] != got_cyc[0] + i ||
                got_last[i] !== ((i == 15) || (i == 31))) begin
                if (bad == 0)
                    $display("FAIL stream_beat[%0d]: tdata=%h tlast=%b need %h %b", i, got_data[i],
                             got_last[i], 8'(i), (i == 15) || (i == 31));
                bad++;
            end
        end
        tests++;
        if (bad != 0 || got_data.size() != 32) begin
            fails++;
            $display("FAIL stream_seq: bad=%0d beats=%0d need 0 32", bad, got_data.size());
        end
        tests++;
        if (done_cnt != 2) begin
            fails++;
            $display("FAIL stream_pkt_done: pulses=%0d need 2", done_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] hold;
        int bad_hold;
        int bad_rd;
        int bad;
        start();
        load(8'h80, 40);
        rst = 1'b0;
        wait_beats(5, 20, "bp_pre");
        bus.i_m_axis_tready = 1'b0;
        hold     = '0;
        bad_hold = 0;
        bad_rd   = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) hold = bus.o_m_axis_tdata;
            if (bus.o_m_axis_tvalid !== 1'b1 || bus.o_m_axis_tdata !== hold) bad_hold++;
            if (i >= 1 && bus.o_rd_en !== 1'b0) bad_rd++;
            tick();
        end
        tests++;
        if (bad_hold != 0) begin
            fails++;
            $display("FAIL bp_hold: unstable cycles=%0d need 0 (held %h)", bad_hold, hold);
        end
        tests++;
        if (bad_rd != 0) begin
            fails++;
            $display("FAIL bp_rd_en: reads while stalled=%0d need 0", bad_rd);
        end
        for (int i = 0; i < 20; i++) begin
            bus.i_m_axis_tready = (i % 2 == 0);
            tick();
        end
        bus.i_m_axis_tready = 1'b1;
        wait_beats(40, 100, "bp");
        repeat (4) tick();
        bad = 0;
        for (int i = 0; i < got_data.size(); i++)
            if (got_data[i] !== 8'(8'h80 + i)) bad++;
        tests++;
        if (bad != 0 || got_data.size() != 40) begin
            fails++;
            $display("FAIL bp_order: bad=%0d beats=%0d need 0 40", bad, got_data.size());
        end
        tests++;
        if (bus.o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL bp_overflow: got %b need 0", bus.o_overflow);
        end
    endtask

    task automatic test_gaps();
        int bad_gap;
        int bad;
        start();
        rst = 1'b0;
        load(8'h10, 5);
        repeat (10) tick();
        tests++;
        if (got_data.size() != 5) begin
            fails++;
            $display("FAIL gap_first: beats=%0d need 5", got_data.size());
        end
        bad_gap = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.o_m_axis_tvalid !== 1'b0) bad_gap++;
            tick();
        end
        tests++;
        if (bad_gap != 0) begin
            fails++;
            $display("FAIL gap_tvalid: valid cycles=%0d need 0", bad_gap);
        end
        load(8'h15, 11);
        wait_beats(16, 40, "gap");
        repeat (3) tick();
        bad = 0;
        for (int i = 0; i < got_data.size(); i++)
            if (got_data[i] !== 8'(8'h10 + i) || got_last[i] !== (i == 15)) bad++;
        tests++;
        if (bad != 0 || got_data.size() != 16) begin
            fails++;
            $display("FAIL gap_seq: bad=%0d beats=%0d need 0 16", bad, got_data.size());
        end
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL gap_pkt_done: pulses=%0d need 1", done_cnt);
        end
    endtask

    task automatic test_enable_drop();
        int bad_on;
        int bad_off;
        int bad;
        start();
        load(8'h20, 20);
        rst    = 1'b0;
        bad_on = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.o_rd_en !== 1'b1) bad_on++;
            tick();
        end
        bus.i_enable = 1'b0;
        bad_off = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.o_rd_en !== 1'b0) bad_off++;
            tick();
        end
        tests++;
        if (bad_on != 0 || bad_off != 0) begin
            fails++;
            $display("FAIL en_rd_en: missing reads=%0d reads while disabled=%0d need 0 0", bad_on, bad_off);
        end
        tests++;
        if (got_data.size() != 5) begin
            fails++;
            $display("FAIL en_drain: beats=%0d need 5", got_data.size());
        end
        bus.i_enable = 1'b1;
        wait_beats(20, 60, "en_resume");
        repeat (3) tick();
        bad = 0;
        for (int i = 0; i < got_data.size(); i++)
            if (got_data[i] !== 8'(8'h20 + i) || got_last[i] !== (i == 15)) bad++;
        tests++;
        if (bad != 0 || got_data.size() != 20 || done_cnt != 1) begin
            fails++;
            $display("FAIL en_seq: bad=%0d beats=%0d pulses=%0d need 0 20 1", bad, got_data.size(), done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        start();
        load(8'h60, 32);
        rst = 1'b0;
        wait_beats(8, 30, "mid_pre");
        rst = 1'b1;
        tests++;
        if (got_data.size() != 8) begin
            fails++;
            $display("FAIL mid_pre_beats: beats=%0d need 8", got_data.size());
        end
        tick();
        fifo_clr = 1'b1;
        tick();
        tick();
        fifo_clr = 1'b0;
        wptr     = 0;
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
        done_cnt = 0;
        load(8'hA0, 20);
        @(negedge clk);
        tests++;
        if ({bus.o_rd_en, bus.o_m_axis_tvalid, bus.o_m_axis_tlast, bus.o_pkt_done} !== 4'd0) begin
            fails++;
            $display("FAIL mid_reset_outputs: rd_en=%b tvalid=%b tlast=%b done=%b need 0",
                     bus.o_rd_en, bus.o_m_axis_tvalid, bus.o_m_axis_tlast, bus.o_pkt_done);
        end
        tick();
        rst = 1'b0;
        wait_beats(20, 60, "mid_post");
        repeat (3) tick();
        bad = 0;
        for (int i = 0; i < got_data.size(); i++)
            if (got_data[i] !== 8'(8'hA0 + i) || got_last[i] !== (i == 15)) bad++;
        tests++;
        if (bad != 0 || got_data.size() != 20) begin
            fails++;
            $display("FAIL mid_seq: bad=%0d beats=%0d need 0 20", bad, got_data.size());
        end
        tests++;
        if (done_cnt != 1) begin
            fails++;
            $display("FAIL mid_pkt_done: pulses=%0d need 1", done_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clk                 = 1'b0;
        cyc                 = 0;
        rst                 = 1'b1;
        fifo_clr            = 1'b1;
        wptr                = 0;
        tests               = 0;
        fails               = 0;
        done_cnt            = 0;
        bus.i_enable        = 1'b0;
        bus.i_m_axis_tready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_gaps();
        test_enable_drop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
